muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 137 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences one MULT/DIV operation at a time for the control unit.
//
// Flow: accept the request and latch its operands, pulse the selected unit's start,
// wait for that unit's done (bounded by TIMEOUT cycles), then write HI/LO.
// A DIV with a zero divisor skips the unit and reports div_zero.
// A unit that never completes reports timeout_err.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid/req_op/req_a/b    request from the control unit (op 0 = MULT, 1 = DIV)
//   req_ready                   high only while idle
//   flush                       synchronous abort of the in-flight operation
//   op_a, op_b                  latched operands to the multiplier/divider
//   mult_start, div_start       one-cycle start pulses
//   mult_done, div_done         unit completion pulses
//   mult_hi/lo, div_quot/rem    unit results, valid with the matching done
//   hi_data/lo_data/hi_write/lo_write  HI/LO register write port
//   busy                        high whenever not idle
//   op_done, div_zero, timeout_err     one-cycle status pulses
module muldiv_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        mult_start,
    output logic        div_start,
    input  logic        mult_done,
    input  logic        div_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        op_done,
    output logic        div_zero,
    output logic        timeout_err
);

    typedef enum logic [2:0] {StIdle, StStart, StWait, StWrite, StErr} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e     state;
    logic       op;
    logic [7:0] wait_cnt;
    logic       sel_done;

    // Only the unit we started may complete the operation.
    assign sel_done  = op ? div_done : mult_done;
    assign busy      = (state != StIdle);
    assign req_ready = (state == StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            op          <= 1'b0;
            wait_cnt    <= 8'd0;
            op_a        <= 32'd0;
            op_b        <= 32'd0;
            hi_data     <= 32'd0;
            lo_data     <= 32'd0;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            hi_write    <= 1'b0;
            lo_write    <= 1'b0;
            op_done     <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Pulses are set on the transition into the state that shows them.
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            hi_write    <= 1'b0;
            lo_write    <= 1'b0;
            op_done     <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;

            unique case (state)
                StIdle: begin
                    // flush in idle suppresses acceptance for that cycle
                    if (req_valid && !flush) begin
                        op   <= req_op;
                        op_a <= req_a;
                        op_b <= req_b;
                        if (req_op && (req_b == 32'd0)) begin
                            state    <= StErr;
                            div_zero <= 1'b1;
                        end else begin
                            state      <= StStart;
                            mult_start <= ~req_op;
                            div_start  <= req_op;
                        end
                    end
                end
                StStart: begin
                    wait_cnt <= 8'd0;
                    state    <= flush ? StIdle : StWait;
                end
                StWait: begin
                    if (flush) begin
                        state <= StIdle;
                    end else if (sel_done) begin
                        // done beats a timeout landing in the same cycle
                        hi_data  <= op ? div_rem  : mult_hi;
                        lo_data  <= op ? div_quot : mult_lo;
                        hi_write <= 1'b1;
                        lo_write <= 1'b1;
                        op_done  <= 1'b1;
                        state    <= StWrite;
                    end else if (wait_cnt == CntLast) begin
                        timeout_err <= 1'b1;
                        state       <= StErr;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                StWrite: state <= StIdle;
                StErr:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: a cycle-indexed expectation table filled from the
// latency rules, compared against the DUT every negedge, plus literal spot checks.
module tb_muldiv_sequencer;

    localparam int TO   = 4;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_op = 1'b0, flush = 1'b0;
    logic [31:0] req_a = '0, req_b = '0;
    logic        mult_done = 1'b0, div_done = 1'b0;
    logic [31:0] mult_hi = '0, mult_lo = '0, div_quot = '0, div_rem = '0;
    logic        req_ready, mult_start, div_start, hi_write, lo_write;
    logic        busy, op_done, div_zero, timeout_err;
    logic [31:0] op_a, op_b, hi_data, lo_data;

    muldiv_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
        .op_a(op_a), .op_b(op_b), .mult_start(mult_start), .div_start(div_start),
        .mult_done(mult_done), .div_done(div_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_quot(div_quot), .div_rem(div_rem), .hi_data(hi_data), .lo_data(lo_data),
        .hi_write(hi_write), .lo_write(lo_write), .busy(busy), .op_done(op_done),
        .div_zero(div_zero), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int tests = 0, fails = 0;
    int c_busy, c_wr, c_done, c_ms, c_ds, c_dz, c_to;

    // Expected outputs per cycle interval (interval c follows the c-th rising edge).
    bit        e_busy[MAXC], e_ms[MAXC], e_ds[MAXC], e_wr[MAXC], e_dz[MAXC], e_to[MAXC];
    bit [31:0] e_hi[MAXC], e_lo[MAXC], e_opa[MAXC], e_opb[MAXC];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void clr_cnt();
        c_busy = 0; c_wr = 0; c_done = 0; c_ms = 0; c_ds = 0; c_dz = 0; c_to = 0;
    endfunction

    function automatic void clear_from(int c);
        for (int i = c; i < MAXC; i++) begin
            e_busy[i] = 0; e_ms[i] = 0; e_ds[i] = 0; e_wr[i] = 0; e_dz[i] = 0; e_to[i] = 0;
        end
    endfunction

    // Fill expectations for a request accepted in interval n; returns its last busy interval.
    function automatic int sched(bit op, bit [31:0] a, bit [31:0] b, int n, int delay, bit give);
        bit [63:0] prod;
        int last;
        prod = {32'd0, a} * {32'd0, b};
        if (op && b == 32'd0) begin
            last = n + 1;
            e_dz[last] = 1;
        end else begin
            e_ms[n + 1] = !op;
            e_ds[n + 1] = op;
            if (give && delay <= TO) begin
                last = n + 2 + delay;
                e_wr[last] = 1;
                e_hi[last] = op ? a % b : prod[63:32];
                e_lo[last] = op ? a / b : prod[31:0];
            end else begin
                last = n + 2 + TO;
                e_to[last] = 1;
            end
        end
        for (int c = n + 1; c <= last; c++) begin
            e_busy[c] = 1; e_opa[c] = a; e_opb[c] = b;
        end
        return last;
    endfunction

    // Compare process.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("rst_ctl", {busy, req_ready, mult_start, div_start, hi_write, lo_write,
                              op_done, div_zero, timeout_err}, 9'b010000000);
            check("rst_data", {op_a, op_b, hi_data, lo_data}, 128'd0);
        end else if (cyc < MAXC) begin
            check("ctl", {busy, req_ready, mult_start, div_start, hi_write, lo_write,
                          op_done, div_zero, timeout_err},
                  {e_busy[cyc], !e_busy[cyc], e_ms[cyc], e_ds[cyc], e_wr[cyc], e_wr[cyc],
                   e_wr[cyc], e_dz[cyc], e_to[cyc]});
            if (e_wr[cyc]) check("hilo", {hi_data, lo_data}, {e_hi[cyc], e_lo[cyc]});
            if (e_busy[cyc]) check("ops", {op_a, op_b}, {e_opa[cyc], e_opb[cyc]});
            c_busy += int'(busy); c_wr += int'(hi_write); c_done += int'(op_done);
            c_ms += int'(mult_start); c_ds += int'(div_start);
            c_dz += int'(div_zero); c_to += int'(timeout_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; the fake unit answers `delay` cycles after the start pulse.
    // noise adds ignored done pulses (other unit always, selected unit in START/ERR).
    task automatic run_op(bit op, bit [31:0] a, bit [31:0] b, int delay, bit give, bit noise);
        int n, last;
        bit real_done, junk, wrote;
        bit [63:0] prod;
        n = cyc;
        prod = {32'd0, a} * {32'd0, b};
        wrote = give && delay <= TO && !(op && b == 32'd0);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        last = sched(op, a, b, n, delay, give);
        step();
        req_valid = 0; req_a = $urandom; req_b = $urandom;
        while (cyc <= last) begin
            real_done = wrote && (cyc == n + 1 + delay);
            junk = noise && (cyc == n + 1 || (cyc == last && !wrote));
            mult_done = op ? noise : (real_done || junk);
            div_done  = op ? (real_done || junk) : noise;
            mult_hi  = (!op && real_done) ? prod[63:32] : $urandom;
            mult_lo  = (!op && real_done) ? prod[31:0]  : $urandom;
            div_rem  = (op && real_done) ? a % b : $urandom;
            div_quot = (op && real_done) ? a / b : $urandom;
            step();
        end
        mult_done = 0; div_done = 0;
    endtask

    initial begin
        int n, n2;
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n2;
        clr_cnt();
        step(); step();
        reset = 0;
        // done pulses while idle are ignored
        mult_done = 1; div_done = 1; step();
        mult_done = 0; div_done = 0; step();

        // MULT 0x10000 * 0x10000, done 3 cycles after start
        clr_cnt();
        run_op(0, 32'h0001_0000, 32'h0001_0000, 3, 1, 0);
        check("t1_writes", c_wr, 1); check("t1_opdone", c_done, 1);
        check("t1_busy", c_busy, 5); check("t1_hi", hi_data, 32'h1); check("t1_lo", lo_data, 0);

        // DIV 7 / 2
        clr_cnt();
        run_op(1, 32'd7, 32'd2, 2, 1, 1);
        check("t2_dstart", c_ds, 1); check("t2_mstart", c_ms, 0);
        check("t2_hi", hi_data, 32'd1); check("t2_lo", lo_data, 32'd3);

        // DIV 5 / 0
        clr_cnt();
        run_op(1, 32'd5, 32'd0, 1, 1, 1);
        step();
        check("t3_dz", c_dz, 1); check("t3_dstart", c_ds, 0);
        check("t3_writes", c_wr, 0); check("t3_busy", c_busy, 1);

        // MULT with done withheld -> timeout
        clr_cnt();
        run_op(0, 32'd9, 32'd9, 0, 0, 1);
        check("t4_to", c_to, 1); check("t4_writes", c_wr, 0); check("t4_busy", c_busy, TO + 2);

        // done on the final WAIT cycle -> normal completion
        clr_cnt();
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, TO, 1, 1);
        check("t5_to", c_to, 0); check("t5_writes", c_wr, 1);
        check("t5_hi", hi_data, 32'hFFFF_FFFE); check("t5_lo", lo_data, 32'h0000_0001);
        clr_cnt();
        run_op(1, 32'h8000_0000, 32'd3, TO, 1, 1);
        check("t5b_lo", lo_data, 32'h2AAA_AAAA); check("t5b_hi", hi_data, 32'd2);

        // flush in WAIT, then a late done
        clr_cnt();
        n = cyc;
        req_valid = 1; req_op = 0; req_a = 32'd6; req_b = 32'd7;
        void'(sched(0, 32'd6, 32'd7, n, 10, 0));
        clear_from(n + 4);
        step(); req_valid = 0;
        step(); step(); flush = 1;
        step(); flush = 0; mult_done = 1; mult_hi = 32'd0; mult_lo = 32'd42;
        step(); mult_done = 0;
        step();
        check("t6_writes", c_wr, 0); check("t6_opdone", c_done, 0); check("t6_busy", c_busy, 3);
        // flush in idle blocks acceptance
        clr_cnt();
        req_valid = 1; flush = 1; step();
        req_valid = 0; flush = 0; step();
        check("t6_idleflush", c_busy, 0);

        // reset while waiting
        clr_cnt();
        n = cyc;
        req_valid = 1; req_op = 0; req_a = 32'd11; req_b = 32'd13;
        void'(sched(0, 32'd11, 32'd13, n, 3, 1));
        step(); req_valid = 0;
        step(); step();
        clear_from(n + 3);
        reset = 1;
        step(); step();
        reset = 0; mult_done = 1; mult_hi = 32'd1; mult_lo = 32'd143;
        step(); mult_done = 0;
        step();
        check("t7_writes", c_wr, 0); check("t7_opa", op_a, 0); check("t7_hi", hi_data, 0);

        // back-to-back with req_valid held high
        clr_cnt();
        n = cyc;
        n2 = n + 5;
        req_valid = 1; req_op = 0; req_a = 32'd3; req_b = 32'd5;
        void'(sched(0, 32'd3, 32'd5, n, 2, 1));
        void'(sched(0, 32'h1234_5678, 32'h100, n2, 1, 1));
        step();
        req_a = 32'h1234_5678; req_b = 32'h100;
        while (cyc <= n2 + 3) begin
            if (cyc == n2 + 1) req_valid = 0;
            mult_done = (cyc == n + 3) || (cyc == n2 + 2);
            mult_hi = (cyc == n + 3) ? 32'd0  : 32'h12;
            mult_lo = (cyc == n + 3) ? 32'd15 : 32'h3456_7800;
            step();
        end
        mult_done = 0;
        check("t8_mstart", c_ms, 2); check("t8_writes", c_wr, 2); check("t8_busy", c_busy, 7);
        check("t8_hi", hi_data, 32'h12); check("t8_lo", lo_data, 32'h3456_7800);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
